cic_os_ctrl: RTL and testbench
==============================

Name: cic_os_ctrl

Overview:
Sequencer for the CIC decimator's oversampling-ratio selection. It accepts ratio-change requests from the configuration interface and drives os_sel to the comb and integrator stages. On every change it runs a flush, then a warm-up, and only then re-enables output. Downstream logic therefore never sees transient garbage from a ratio switch. It sits between the register block and the comb stage and registers the comb output with a valid qualifier.

Parameters:
ODW, 16, data width of comb output and data_out
FLUSH_CYC, 4, clk_div cycles int_clr is held and os_sel forced to 3'b000 during flush (>=1)
WARMUP_SMP, 3, clk_div cycles of muted output after the new os_sel is applied (>=1)
CNTW, 8, width of the internal flush/warm-up counter; must hold max(FLUSH_CYC, WARMUP_SMP)

Ports:
clk_div  in  1  decimated clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cfg_req  in  1  single-cycle request to apply cfg_os_sel
cfg_os_sel  in  3  requested ratio; 3'b000 = disable, 3'b001..3'b110 valid, 3'b111 illegal
cfg_ack  out  1  single-cycle pulse: request completed
cfg_err  out  1  single-cycle pulse: illegal request rejected
busy  out  1  high in FLUSH or WARMUP
os_sel  out  3  ratio select driven to comb/integrators (registered)
int_clr  out  1  synchronous clear to integrators (registered)
comb_data  in  ODW  comb stage output
data_out  out  ODW  registered, gated comb output
data_valid  out  1  data_out qualifier
sat_cnt  out  16  saturation-event count (see Optional Feature)

Behaviour:
- Reset values: os_sel=3'b000, int_clr=0, cfg_ack=0, cfg_err=0, busy=0, data_out=0, data_valid=0, sat_cnt=0. State is IDLE, target=3'b000, counter=0. A reset asserted mid-flush or mid-warm-up aborts immediately to these values; no ack is issued.
- States: IDLE, FLUSH, WARMUP, RUN.
- IDLE: os_sel=000, data_valid=0, data_out=0.
  - cfg_req with a valid nonzero ratio: latch target, go to FLUSH, load counter=FLUSH_CYC-1.
  - cfg_req with 000: cfg_ack next cycle, stay in IDLE.
- FLUSH: os_sel=000 (comb clears its history), int_clr=1, busy=1, data_valid=0. Counter decrements each cycle. At 0, go to WARMUP with os_sel=target, int_clr=0, counter=WARMUP_SMP-1. FLUSH lasts exactly FLUSH_CYC cycles.
- WARMUP: os_sel=target, busy=1, data_valid=0, data_out=0. At counter 0, go to RUN. cfg_ack pulses in the first RUN cycle.
- RUN: each cycle data_out<=comb_data and data_valid=1, so data_out has one cycle of latency from comb_data.
  - cfg_req equal to the current target: ack next cycle, no disruption.
  - cfg_req with a different valid nonzero ratio: go to FLUSH; data_valid drops the next cycle.
  - cfg_req with 000: go to IDLE, cfg_ack next cycle.
- cfg_req during FLUSH/WARMUP: relatch target and restart FLUSH with a full counter reload. A single ack is issued only when RUN is reached with the final target; superseded requests are never acked.
- A 000 request during FLUSH/WARMUP goes to IDLE and acks next cycle.
- cfg_os_sel=3'b111 in any state: cfg_err pulses next cycle. State, target and outputs are unchanged, and no ack is issued.
- Total change latency, from cfg_req to the first valid sample: 1 + FLUSH_CYC + WARMUP_SMP cycles.

Optional Feature:
Macro CIC_SAT_MON_EN.
- Defined: in RUN, sat_cnt increments, saturating at 16'hFFFF, each cycle comb_data equals {1'b0,{ODW-1{1'b1}}} or {1'b1,{ODW-1{1'b0}}}. sat_cnt clears on entry to FLUSH and on reset.
- Undefined: the counter logic is omitted and sat_cnt is tied to 0.

Test Plan:
- Reset, then cfg_req with cfg_os_sel=3'b011 (FLUSH_CYC=4, WARMUP_SMP=3) -> busy for 7 cycles; int_clr high for exactly 4; os_sel 000 then 011; cfg_ack and first data_valid 8 cycles after cfg_req; data_out tracks comb_data with 1-cycle delay.
- In RUN (011), cfg_req with 011 -> cfg_ack next cycle; data_valid never drops.
- In RUN (011), cfg_req with 101, then a second cfg_req with 010 three cycles later -> flush restarts; exactly one cfg_ack; final os_sel=010; 101 is never acked.
- cfg_req with 3'b111 in RUN -> cfg_err pulse; os_sel stays 011; data_valid stays 1; no cfg_ack.
- reset_n asserted during WARMUP -> all outputs return to reset values in the same cycle; no ack after release.
- CIC_SAT_MON_EN defined, RUN, comb_data=16'h7FFF for 5 cycles and 16'h8000 for 2 -> sat_cnt=7; a new ratio request clears it to 0.

Source files
------------

// File: rtl/cic_os_ctrl.sv
// CIC oversampling-ratio sequencer: flush, warm-up, then gated comb output.
// Optional saturation monitor enabled by defining CIC_SAT_MON_EN.
module cic_os_ctrl #(
   parameter int ODW        = 16,
   parameter int FLUSH_CYC  = 4,
   parameter int WARMUP_SMP = 3,
   parameter int CNTW       = 8
) (
   input  logic           clk_div,
   input  logic           reset_n,
   input  logic           cfg_req,
   input  logic [2:0]     cfg_os_sel,
   output logic           cfg_ack,
   output logic           cfg_err,
   output logic           busy,
   output logic [2:0]     os_sel,
   output logic           int_clr,
   input  logic [ODW-1:0] comb_data,
   output logic [ODW-1:0] data_out,
   output logic           data_valid,
   output logic [15:0]    sat_cnt
);

   typedef enum logic [1:0] {IDLE, FLUSH, WARMUP, RUN} state_t;

   localparam logic [CNTW-1:0] FL_LD = CNTW'(FLUSH_CYC - 1);
   localparam logic [CNTW-1:0] WU_LD = CNTW'(WARMUP_SMP - 1);

   state_t          state, state_nx;
   logic [2:0]      target, target_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            ack_nx;
   logic            req_ok;

   assign req_ok = cfg_req && (cfg_os_sel != 3'b111);

   always_comb begin
      state_nx  = state;
      target_nx = target;
      cnt_nx    = cnt;
      ack_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_ok) begin
               if (cfg_os_sel == 3'b000) begin
                  ack_nx = 1'b1;
               end else begin
                  target_nx = cfg_os_sel;
                  state_nx  = FLUSH;
                  cnt_nx    = FL_LD;
               end
            end
         end
         FLUSH, WARMUP: begin
            if (req_ok) begin
               target_nx = cfg_os_sel;
               if (cfg_os_sel == 3'b000) begin
                  state_nx = IDLE;
                  ack_nx   = 1'b1;
               end else begin
                  state_nx = FLUSH;
                  cnt_nx   = FL_LD;
               end
            end else if (cnt != '0) begin
               cnt_nx = cnt - CNTW'(1);
            end else if (state == FLUSH) begin
               state_nx = WARMUP;
               cnt_nx   = WU_LD;
            end else begin
               state_nx = RUN;
               ack_nx   = 1'b1;
            end
         end
         RUN: begin
            if (req_ok) begin
               if (cfg_os_sel == 3'b000) begin
                  state_nx  = IDLE;
                  target_nx = 3'b000;
                  ack_nx    = 1'b1;
               end else if (cfg_os_sel == target) begin
                  ack_nx = 1'b1;
               end else begin
                  target_nx = cfg_os_sel;
                  state_nx  = FLUSH;
                  cnt_nx    = FL_LD;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk_div or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         target     <= 3'b000;
         cnt        <= '0;
         os_sel     <= 3'b000;
         int_clr    <= 1'b0;
         busy       <= 1'b0;
         cfg_ack    <= 1'b0;
         cfg_err    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         target     <= target_nx;
         cnt        <= cnt_nx;
         os_sel     <= (state_nx == WARMUP || state_nx == RUN) ?
                       target_nx : 3'b000;
         int_clr    <= (state_nx == FLUSH);
         busy       <= (state_nx == FLUSH || state_nx == WARMUP);
         cfg_ack    <= ack_nx;
         cfg_err    <= cfg_req && (cfg_os_sel == 3'b111);
         data_out   <= (state_nx == RUN) ? comb_data : '0;
         data_valid <= (state_nx == RUN);
      end
   end

`ifdef CIC_SAT_MON_EN
   localparam logic [ODW-1:0] POS_FS = {1'b0, {(ODW-1){1'b1}}};
   localparam logic [ODW-1:0] NEG_FS = {1'b1, {(ODW-1){1'b0}}};

   logic [15:0] sat_q;
   logic        at_fs;

   assign at_fs = (comb_data == POS_FS) || (comb_data == NEG_FS);

   always_ff @(posedge clk_div or negedge reset_n) begin
      if (!reset_n) begin
         sat_q <= '0;
      end else if (state_nx == FLUSH) begin
         sat_q <= '0;
      end else if (state == RUN && at_fs && sat_q != 16'hFFFF) begin
         sat_q <= sat_q + 16'd1;
      end
   end

   assign sat_cnt = sat_q;
`else
   assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cic_os_ctrl.sv
// Bench for cic_os_ctrl: directed plan plus random requests against a
// timeline-based reference model.
module tb_cic_os_ctrl;

   localparam int ODW = 16;
   localparam int F   = 4;
   localparam int W   = 3;

   logic           clk_div = 1'b0;
   logic           reset_n = 1'b1;
   logic           cfg_req = 1'b0;
   logic [2:0]     cfg_os_sel = 3'b000;
   logic [ODW-1:0] comb_data = '0;
   logic           cfg_ack, cfg_err, busy, int_clr, data_valid;
   logic [2:0]     os_sel;
   logic [ODW-1:0] data_out;
   logic [15:0]    sat_cnt;

   cic_os_ctrl #(.ODW(ODW), .FLUSH_CYC(F), .WARMUP_SMP(W), .CNTW(8)) dut (
      .clk_div(clk_div), .reset_n(reset_n), .cfg_req(cfg_req),
      .cfg_os_sel(cfg_os_sel), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
      .busy(busy), .os_sel(os_sel), .int_clr(int_clr),
      .comb_data(comb_data), .data_out(data_out),
      .data_valid(data_valid), .sat_cnt(sat_cnt)
   );

   always #5 clk_div = ~clk_div;

   int checks = 0;
   int failures = 0;

   // Model: mode 0 idle, 1 changing (age = edges since accepted request), 2 run
   int             m_mode, m_age, m_sat;
   logic [2:0]     m_tgt;
   logic           m_ack, m_err;
   logic [ODW-1:0] m_dout;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_sat = 0; m_tgt = 3'b000;
      m_ack = 1'b0; m_err = 1'b0; m_dout = '0;
   endtask

   task automatic model_edge(input logic req, input logic [2:0] sel,
                             input logic [ODW-1:0] d);
      bit was_run, to_chg;
      was_run = (m_mode == 2);
      to_chg  = 1'b0;
      m_ack   = 1'b0;
      m_err   = req && (sel == 3'b111);
      if (req && sel != 3'b111) begin
         if (sel == 3'b000) begin
            m_mode = 0; m_ack = 1'b1;
         end else if (m_mode == 2 && sel == m_tgt) begin
            m_ack = 1'b1;
         end else begin
            m_mode = 1; m_tgt = sel; m_age = 1; to_chg = 1'b1;
         end
      end else if (m_mode == 1) begin
         m_age++;
         if (m_age == F + W + 1) begin
            m_mode = 2; m_ack = 1'b1;
         end
      end
`ifdef CIC_SAT_MON_EN
      if (to_chg) m_sat = 0;
      else if (was_run && (d == 16'h7FFF || d == 16'h8000) && m_sat < 65535)
         m_sat++;
`endif
      m_dout = (m_mode == 2) ? d : '0;
   endtask

   task automatic check_all();
      logic [2:0] e_os;
      e_os = (m_mode == 2 || (m_mode == 1 && m_age > F)) ? m_tgt : 3'b000;
      chk("os_sel", os_sel, e_os);
      chk("int_clr", int_clr, (m_mode == 1 && m_age <= F));
      chk("busy", busy, (m_mode == 1));
      chk("data_valid", data_valid, (m_mode == 2));
      chk("data_out", data_out, m_dout);
      chk("cfg_ack", cfg_ack, m_ack);
      chk("cfg_err", cfg_err, m_err);
      chk("sat_cnt", sat_cnt, m_sat);
   endtask

   task automatic step(input logic req, input logic [2:0] sel,
                       input logic [ODW-1:0] d);
      cfg_req = req; cfg_os_sel = sel; comb_data = d;
      @(posedge clk_div);
      #1;
      model_edge(req, sel, d);
      cfg_req = 1'b0;
      check_all();
   endtask

   function automatic logic [ODW-1:0] rnd_data();
      return ODW'($urandom);
   endfunction

   initial begin
      int nb, ni, ack_at, dv_at, acks;
      logic [2:0] s;
      logic [ODW-1:0] d;

      // Reset
      model_reset();
      #1 reset_n = 1'b0;
      #10;
      check_all();
      @(negedge clk_div) reset_n = 1'b1;
      step(0, 3'b000, rnd_data());
      step(0, 3'b000, rnd_data());

      // First ratio change: timeline of busy/int_clr/ack/valid
      nb = 0; ni = 0; ack_at = -1; dv_at = -1;
      step(1, 3'b011, rnd_data());
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) step(0, 3'b000, rnd_data());
         if (busy) nb++;
         if (int_clr) ni++;
         if (cfg_ack && ack_at < 0) ack_at = i;
         if (data_valid && dv_at < 0) dv_at = i;
      end
      chk("busy_len", nb, 7);
      chk("clr_len", ni, 4);
      chk("ack_lat", ack_at, 8);
      chk("valid_lat", dv_at, 8);

      // Same-ratio request in RUN
      step(1, 3'b011, rnd_data());
      chk("same_ack", cfg_ack, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 3'b000, rnd_data());

      // Superseded request
      acks = 0;
      step(1, 3'b101, rnd_data());
      acks += int'(cfg_ack);
      step(0, 3'b000, rnd_data()); acks += int'(cfg_ack);
      step(0, 3'b000, rnd_data()); acks += int'(cfg_ack);
      step(1, 3'b010, rnd_data()); acks += int'(cfg_ack);
      for (int i = 0; i < 10; i++) begin
         step(0, 3'b000, rnd_data());
         acks += int'(cfg_ack);
      end
      chk("supersede_acks", acks, 1);
      chk("final_os", os_sel, 3'b010);

      // Illegal request in RUN
      step(1, 3'b111, rnd_data());
      chk("err_pulse", cfg_err, 1'b1);
      chk("err_os_hold", os_sel, 3'b010);
      step(0, 3'b000, rnd_data());

      // Reset during warm-up
      step(1, 3'b011, rnd_data());
      for (int i = 0; i < 5; i++) step(0, 3'b000, rnd_data());
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk_div) reset_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 3'b000, rnd_data());
         acks += int'(cfg_ack);
      end
      chk("no_ack_after_rst", acks, 0);

      // Saturation monitor
      step(1, 3'b011, rnd_data());
      for (int i = 0; i < 8; i++) step(0, 3'b000, 16'h1234);
      for (int i = 0; i < 5; i++) step(0, 3'b000, 16'h7FFF);
      for (int i = 0; i < 2; i++) step(0, 3'b000, 16'h8000);
      step(0, 3'b000, 16'h0000);
`ifdef CIC_SAT_MON_EN
      chk("sat_seven", sat_cnt, 16'd7);
`else
      chk("sat_tied", sat_cnt, 16'd0);
`endif
      step(1, 3'b100, 16'h7FFF);
      chk("sat_clear", sat_cnt, 16'd0);

      // Random requests
      for (int i = 0; i < 500; i++) begin
         s = 3'($urandom_range(0, 7));
         d = ($urandom_range(0, 7) == 0) ?
             (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000) : rnd_data();
         step(($urandom_range(0, 9) == 0), s, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
